// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the memory-port arbiter and its lane aligner.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    // True when func3 names an access width that may be used with this direction.
    // Unsigned widths exist for loads only.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane aligner: store strobes/replication and load lane
// select with sign or zero extension, plus the natural-alignment check.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then shape strobes/data by access width.
    always_comb begin
        byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        wstrb      = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        case (func3)
            F3_B, F3_BU: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = func3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H, F3_HU: begin
                wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = func3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            F3_W: begin
                wstrb      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
        // Reads never carry strobes.
        if (!we) begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// the load/store path; each access runs IDLE -> ISSUE -> WAIT -> RESP.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_func3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    arb_state_e  state_q, state_d;
    grant_e      last_q, last_d;
    grant_e      gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        is_idle;
    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic        al_we;
    logic [31:0] al_wdata_in;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misaligned;
    logic        pick_d;
    logic        req_illegal;
    logic        timeout;

    // In IDLE the aligner checks the incoming D request; afterwards it shapes
    // the latched request and the returning read word.
    assign is_idle     = (state_q == ST_IDLE);
    assign al_f3       = is_idle ? d_func3 : f3_q;
    assign al_lo       = is_idle ? d_addr[1:0] : addr_q[1:0];
    assign al_we       = is_idle ? d_we : we_q;
    assign al_wdata_in = is_idle ? d_wdata : wdata_q;

    lsu_align u_align (
        .func3      (al_f3),
        .addr_lo    (al_lo),
        .we         (al_we),
        .wdata      (al_wdata_in),
        .rdata      (mem_rdata),
        .wstrb      (al_wstrb),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_misaligned)
    );

    // D wins when it is alone or when I was granted last.
    assign pick_d      = d_req && (!if_req || (last_q == GNT_I));
    assign req_illegal = pick_d ? (!f3_legal(d_func3, d_we) || al_misaligned)
                                : (if_addr[1:0] != 2'b00);
    assign timeout     = (cnt_q >= 8'(MEM_TIMEOUT - 1));

    // Next-state logic: grant and latch, issue, wait, respond.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    if (pick_d) begin
                        gnt_d   = GNT_D;
                        we_d    = d_we;
                        f3_d    = d_func3;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        gnt_d   = GNT_I;
                        we_d    = 1'b0;
                        f3_d    = F3_W;
                        addr_d  = if_addr;
                        wdata_d = 32'b0;
                    end
                    last_d  = pick_d ? GNT_D : GNT_I;
                    cnt_d   = 8'd0;
                    rdata_d = 32'b0;
                    err_d   = req_illegal;
                    state_d = req_illegal ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ready) begin
                    state_d = ST_WAIT;
                end else if (timeout) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'b0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'b0 : al_rdata;
                end else if (timeout) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= GNT_I;
            gnt_q   <= GNT_I;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory side is driven only while issuing, so it idles at zero.
    assign mem_req   = (state_q == ST_ISSUE);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'b0;
    assign mem_wdata = mem_we ? al_wdata : 32'b0;
    assign mem_wstrb = mem_req ? al_wstrb : 4'b0000;

    // Response pulse goes to whichever requester holds the grant.
    assign if_rvalid = (state_q == ST_RESP) && (gnt_q == GNT_I);
    assign if_rdata  = if_rvalid ? rdata_q : 32'b0;
    assign if_err    = if_rvalid & err_q;
    assign d_rvalid  = (state_q == ST_RESP) && (gnt_q == GNT_D);
    assign d_rdata   = d_rvalid ? rdata_q : 32'b0;
    assign d_err     = d_rvalid & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference
// model and a reactive memory whose accept/response delays are chosen per access.
module tb_mem_port_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_func3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.MEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_func3    (d_func3),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          last_served;      // 0 = I, 1 = D
    logic [31:0] mem [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({if_rvalid, if_err, d_rvalid, d_err, mem_req, mem_we, mem_wstrb}), 32'h0);
        check({tag, "_data"}, if_rdata | d_rdata | mem_addr | mem_wdata, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_served = 0;
    endtask

    task automatic set_i(input logic [31:0] a);
        if_req = 1'b1; if_addr = a;
    endtask

    task automatic set_d(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_func3 = f3; d_addr = a; d_wdata = wd;
    endtask

    // Run one access to completion. Entered at a negedge in an IDLE cycle with
    // requests already driven. The memory accepts in ISSUE cycle index acc_dly
    // and answers rsp_dly cycles after acceptance.
    task automatic serve(input string tag, input int acc_dly, input int rsp_dly);
        bit          win_d, illegal, exp_we, exp_err, uns, done;
        int          size, off, exp_lat, exp_reqcyc, n, reqcyc;
        logic [31:0] a, w, exp_rdata, exp_wdata, lv;
        logic [3:0]  exp_strb;

        win_d       = d_req && (!if_req || last_served == 0);
        last_served = win_d ? 1 : 0;
        a           = win_d ? d_addr : if_addr;
        off         = int'(a[1:0]);
        w           = mem[a[9:2]];
        exp_we      = 1'b0;
        exp_strb    = 4'b0000;
        exp_wdata   = 32'h0;
        exp_rdata   = w;
        if (win_d) begin
            size = (d_func3 == 3'd0 || d_func3 == 3'd4) ? 1 :
                   (d_func3 == 3'd1 || d_func3 == 3'd5) ? 2 :
                   (d_func3 == 3'd2) ? 4 : 0;
            uns  = (d_func3 == 3'd4 || d_func3 == 3'd5);
            if (size == 0) illegal = 1'b1;
            else illegal = (d_we && uns) || (off % size != 0);
            exp_we = d_we;
            if (!illegal && d_we) begin
                exp_strb  = 4'(((1 << size) - 1) << off);
                exp_wdata = (size == 1) ? {4{d_wdata[7:0]}} :
                            (size == 2) ? {2{d_wdata[15:0]}} : d_wdata;
            end
            lv = w >> (8 * off);
            if (size == 1) begin
                lv = lv & 32'h0000_00FF;
                if (!uns && lv[7]) lv = lv | 32'hFFFF_FF00;
            end else if (size == 2) begin
                lv = lv & 32'h0000_FFFF;
                if (!uns && lv[15]) lv = lv | 32'hFFFF_0000;
            end
            exp_rdata = d_we ? 32'h0 : lv;
        end else begin
            illegal = (off != 0);
        end

        if (illegal) begin
            exp_lat = 1; exp_err = 1'b1; exp_reqcyc = 0; exp_rdata = 32'h0;
        end else if (acc_dly + rsp_dly <= TMO - 1) begin
            exp_lat = acc_dly + rsp_dly + 2; exp_err = 1'b0; exp_reqcyc = acc_dly + 1;
        end else begin
            exp_lat = TMO + 1; exp_err = 1'b1; exp_rdata = 32'h0;
            exp_reqcyc = (acc_dly <= TMO - 1) ? acc_dly + 1 : TMO;
        end

        // The bench memory commits an accepted store.
        if (!illegal && exp_we && acc_dly <= TMO - 1) begin
            for (int b = 0; b < 4; b++) begin
                if (exp_strb[b]) mem[a[9:2]][8*b +: 8] = exp_wdata[8*b +: 8];
            end
        end

        n = 0; reqcyc = 0; done = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (mem_req) begin
                reqcyc++;
                if (reqcyc == 1) begin
                    check({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
                    check({tag, "_mwe"}, 32'(mem_we), 32'(exp_we));
                    check({tag, "_mstrb"}, 32'(mem_wstrb), 32'(exp_strb));
                    if (exp_we) check({tag, "_mwdata"}, mem_wdata, exp_wdata);
                end
            end
            if (if_rvalid || d_rvalid) begin
                done = 1'b1;
                check({tag, "_port"}, 32'({if_rvalid, d_rvalid}), win_d ? 32'h1 : 32'h2);
                check({tag, "_lat"}, 32'(n), 32'(exp_lat));
                check({tag, "_err"}, 32'(win_d ? d_err : if_err), 32'(exp_err));
                check({tag, "_rdata"}, win_d ? d_rdata : if_rdata, exp_rdata);
                check({tag, "_reqcyc"}, 32'(reqcyc), 32'(exp_reqcyc));
                $display("txn %s port=%s addr=%h lat=%0d err=%0b rdata=%h",
                         tag, win_d ? "D" : "I", a, n,
                         win_d ? d_err : if_err, win_d ? d_rdata : if_rdata);
                if (win_d) d_req = 1'b0;
                else if_req = 1'b0;
            end else if (!illegal) begin
                if (n - 1 == acc_dly) mem_ready = 1'b1;
                if (n - 1 == acc_dly + rsp_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = w;
                end
            end
        end
        if (!done) check({tag, "_no_response"}, 32'h0, 32'h1);
        // Step through the RESP->IDLE edge so the next access starts in IDLE.
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_func3 = '0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        do_reset();
        check_all_zero("reset");

        // Signed byte load from the top lane.
        mem[8'h40] = 32'h80FF_1234;
        set_d(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        serve("lb_sext", 0, 1);

        // Halfword store to the upper lane.
        set_d(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
        serve("sh_upper", 1, 2);

        // Round-robin after reset: D first, then alternating while both hold.
        do_reset();
        set_i(32'h0000_0010);
        set_d(1'b0, 3'b010, 32'h0000_0020, 32'h0);
        for (int k = 0; k < 6; k++) begin
            serve("rr", 0, 1);
            if (!if_req) set_i(32'h0000_0010 + 32'(k * 4));
            if (!d_req) set_d(1'b0, 3'b010, 32'h0000_0020 + 32'(k * 4), 32'h0);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Illegal accesses never reach memory.
        set_d(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        serve("lw_misal", 0, 1);
        set_i(32'h0000_0002);
        serve("fetch_misal", 0, 1);
        set_d(1'b1, 3'b100, 32'h0000_0030, 32'h0);
        serve("sbu_illegal", 0, 1);

        // Memory never accepts: timeout error after TMO issue cycles.
        set_i(32'h0000_0044);
        serve("timeout", TMO + 5, 1);

        // Reset in WAIT, late mem_rvalid in IDLE must be ignored.
        do_reset();
        set_d(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_issue", 32'(mem_req), 32'h1);
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        check("rst_mid_wait", 32'(mem_req), 32'h0);
        rst = 1'b1;
        d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_mid_after");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_all_zero("rst_late_rvalid");
        last_served = 0;
        set_d(1'b0, 3'b101, 32'h0000_0042, 32'h0);
        serve("post_rst", 0, 1);

        // Randomized mix of fetches and loads/stores with varied memory timing.
        for (int t = 0; t < 150; t++) begin
            if (!if_req && $urandom_range(0, 2) != 0) begin
                set_i(($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
            end
            if (!d_req && ($urandom_range(0, 2) != 0 || !if_req)) begin
                set_d(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)), $urandom, $urandom);
            end
            serve($sformatf("rnd%0d", t), $urandom_range(0, 4), $urandom_range(1, 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
